// File: rtl/acc_pkg.sv
// Shared accelerator-interface types: C-channel request/response structs and scheduler state.
package acc_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned IdWidth   = 5;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] data_arga;
        logic [IdWidth-1:0]   id;
    } acc_c_q_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [IdWidth-1:0]   id;
        logic                 error;
    } acc_c_p_t;

    typedef struct packed {
        acc_c_q_t q;
        logic     q_valid;
        logic     p_ready;
    } acc_c_req_t;

    typedef struct packed {
        acc_c_p_t p;
        logic     p_valid;
        logic     q_ready;
    } acc_c_rsp_t;

    typedef enum logic [1:0] {
        ACTIVE,
        DRAIN,
        FLUSHED
    } acc_sched_state_e;

    // Index width for a counter holding values 0..num-1; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

endpackage

// File: rtl/delta_counter.sv
// Up/down counter stepping by delta_i, with synchronous clear and parallel load.
module delta_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] delta_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] counter_q, counter_d;

    always_comb begin
        counter_d = counter_q;
        if (clear_i) begin
            counter_d = '0;
        end else if (load_i) begin
            counter_d = d_i;
        end else if (en_i) begin
            counter_d = down_i ? (counter_q - delta_i) : (counter_q + delta_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_d;
        end
    end

    assign q_o = counter_q;

endmodule

// File: rtl/acc_offload_scheduler.sv
// Caps in-flight offloads, blocks address switches until drained, and drains on flush.
//   state   | meaning
//   ACTIVE  | requests pass when allowed
//   DRAIN   | issue stopped, waiting for in-flight responses
//   FLUSHED | drained, flush acknowledged until flush_i drops
module acc_offload_scheduler #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         acc_c_req_t    = acc_pkg::acc_c_req_t,
    parameter type         acc_c_rsp_t    = acc_pkg::acc_c_rsp_t,
    localparam int unsigned CntWidth      = acc_pkg::idx_width(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    output logic                flush_ack_o,
    output logic                busy_o,
    output logic [CntWidth-1:0] outstanding_o,
    input  acc_c_req_t          acc_c_slv_req_i,
    output acc_c_rsp_t          acc_c_slv_rsp_o,
    output acc_c_req_t          acc_c_mst_req_o,
    input  acc_c_rsp_t          acc_c_mst_rsp_i
);

    import acc_pkg::*;

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    acc_sched_state_e     state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [AddrWidth-1:0] cur_addr_q;
    logic                 allow, iss, ret, ret_eff, cnt_en;

    // allow depends only on registered state and the request itself, never on q_ready.
    always_comb begin
        allow = 1'b0;
        if (state_q == ACTIVE) begin
            allow = (cnt_q == '0) ||
                    ((acc_c_slv_req_i.q.addr == cur_addr_q) && (cnt_q < MaxCnt));
        end
    end

    always_comb begin
        acc_c_mst_req_o         = acc_c_slv_req_i;
        acc_c_mst_req_o.q_valid = acc_c_slv_req_i.q_valid & allow;
        acc_c_slv_rsp_o         = acc_c_mst_rsp_i;
        acc_c_slv_rsp_o.q_ready = acc_c_mst_rsp_i.q_ready & allow;
    end

    assign iss     = acc_c_mst_req_o.q_valid & acc_c_mst_rsp_i.q_ready;
    assign ret     = acc_c_mst_rsp_i.p_valid & acc_c_slv_req_i.p_ready;
    assign ret_eff = ret & (cnt_q != '0);
    assign cnt_en  = iss ^ ret_eff;

    delta_counter #(
        .WIDTH (CntWidth)
    ) i_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (1'b0),
        .en_i    (cnt_en),
        .load_i  (1'b0),
        .down_i  (ret_eff),
        .delta_i (CntWidth'(1)),
        .d_i     ('0),
        .q_o     (cnt_q)
    );

    // Look-ahead of the counter so DRAIN can leave in the same edge the last response lands.
    always_comb begin
        cnt_d = cnt_q;
        if (iss && !ret_eff) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!iss && ret_eff) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_addr_q <= '0;
        end else if (iss) begin
            cur_addr_q <= acc_c_slv_req_i.q.addr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACTIVE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACTIVE: begin
                if (flush_i && !(acc_c_mst_req_o.q_valid && !acc_c_mst_rsp_i.q_ready)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!flush_i) begin
                    state_d = ACTIVE;
                end else if (cnt_d == '0) begin
                    state_d = FLUSHED;
                end
            end
            FLUSHED: begin
                if (!flush_i) begin
                    state_d = ACTIVE;
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

    assign flush_ack_o   = (state_q == FLUSHED);
    assign busy_o        = (cnt_q != '0);
    assign outstanding_o = cnt_q;

`ifndef SYNTHESIS
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ret |-> (cnt_q != '0));
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= MaxCnt);
    a_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (acc_c_mst_req_o.q_valid && !acc_c_mst_rsp_i.q_ready) |=> acc_c_mst_req_o.q_valid);
`endif

endmodule

// File: tb/tb_acc_offload_scheduler.sv
// Bench for acc_offload_scheduler: expected issue addresses queued at drive time, popped on handshake.
module tb_acc_offload_scheduler;

    import acc_pkg::*;

    localparam int unsigned MaxOut = 4;
    localparam int unsigned CntW   = idx_width(MaxOut + 1);

    logic            clk_i   = 1'b0;
    logic            rst_ni  = 1'b0;
    logic            flush_i = 1'b0;
    logic            flush_ack_o;
    logic            busy_o;
    logic [CntW-1:0] outstanding_o;
    acc_c_req_t      slv_req, mst_req;
    acc_c_rsp_t      slv_rsp, mst_rsp;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    acc_offload_scheduler #(
        .AddrWidth      (32),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .flush_ack_o     (flush_ack_o),
        .busy_o          (busy_o),
        .outstanding_o   (outstanding_o),
        .acc_c_slv_req_i (slv_req),
        .acc_c_slv_rsp_o (slv_rsp),
        .acc_c_mst_req_o (mst_req),
        .acc_c_mst_rsp_i (mst_rsp)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [31:0] a);
        slv_req.q_valid     = v;
        slv_req.q.addr      = a;
        slv_req.q.data_arga = a ^ 32'hA5A5_0000;
    endtask

    task automatic respond(input int n);
        mst_rsp.p_valid = 1'b1;
        repeat (n) tick();
        mst_rsp.p_valid = 1'b0;
    endtask

    // Handshake monitor: inputs are stable at the falling edge, so a visible handshake lands next edge.
    always @(negedge clk_i) begin
        if (rst_ni && mst_req.q_valid && mst_rsp.q_ready) begin
            check("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                check("sb_issue_addr", mst_req.q.addr, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        slv_req         = '0;
        mst_rsp         = '0;
        slv_req.p_ready = 1'b1;

        // reset values, combinational path live in reset
        repeat (2) @(posedge clk_i);
        #1;
        drive_req(1'b1, 32'h5);
        settle();
        check("rst_outstanding", 32'(outstanding_o), 32'd0);
        check("rst_flush_ack", 32'(flush_ack_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_q_valid_follows", 32'(mst_req.q_valid), 32'd1);
        drive_req(1'b0, 32'h0);
        tick();
        rst_ni          = 1'b1;
        mst_rsp.q_ready = 1'b1;

        // single issue and response pass-through
        tick();
        drive_req(1'b1, 32'h5);
        exp_q.push_back(32'h5);
        settle();
        check("t1_slv_q_ready", 32'(slv_rsp.q_ready), 32'd1);
        tick();
        drive_req(1'b0, 32'h0);
        settle();
        check("t1_outstanding", 32'(outstanding_o), 32'd1);
        check("t1_busy", 32'(busy_o), 32'd1);
        mst_rsp.p.data  = 32'hDEAD_BEEF;
        mst_rsp.p_valid = 1'b1;
        settle();
        check("t1_p_data", slv_rsp.p.data, 32'hDEAD_BEEF);
        check("t1_p_valid", 32'(slv_rsp.p_valid), 32'd1);
        check("t1_p_ready", 32'(mst_req.p_ready), 32'd1);
        tick();
        mst_rsp.p_valid = 1'b0;
        settle();
        check("t1_after_ret", 32'(outstanding_o), 32'd0);

        // fill to MaxOutstanding, fifth waits for a response
        tick();
        drive_req(1'b1, 32'h5);
        for (int i = 0; i < 5; i++) exp_q.push_back(32'h5);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t2_count", 32'(outstanding_o), 32'(i));
        end
        check("t2_full_q_ready", 32'(slv_rsp.q_ready), 32'd0);
        check("t2_full_mst_valid", 32'(mst_req.q_valid), 32'd0);
        tick();
        check("t2_full_hold", 32'(outstanding_o), 32'd4);
        check("t2_full_q_ready2", 32'(slv_rsp.q_ready), 32'd0);
        mst_rsp.p_valid = 1'b1;
        tick();
        mst_rsp.p_valid = 1'b0;
        settle();
        check("t2_after_ret_cnt", 32'(outstanding_o), 32'd3);
        check("t2_after_ret_q_ready", 32'(slv_rsp.q_ready), 32'd1);
        tick();
        drive_req(1'b0, 32'h0);
        settle();
        check("t2_refill", 32'(outstanding_o), 32'd4);
        respond(4);
        settle();
        check("t2_drained", 32'(outstanding_o), 32'd0);

        // address switch waits for drain
        tick();
        drive_req(1'b1, 32'h5);
        exp_q.push_back(32'h5);
        exp_q.push_back(32'h5);
        tick();
        tick();
        drive_req(1'b1, 32'h9);
        exp_q.push_back(32'h9);
        settle();
        check("t3_cnt2", 32'(outstanding_o), 32'd2);
        check("t3_blocked", 32'(slv_rsp.q_ready), 32'd0);
        check("t3_blocked_mst", 32'(mst_req.q_valid), 32'd0);
        mst_rsp.p_valid = 1'b1;
        tick();
        settle();
        check("t3_blocked_cnt1", 32'(slv_rsp.q_ready), 32'd0);
        tick();
        mst_rsp.p_valid = 1'b0;
        settle();
        check("t3_cnt0", 32'(outstanding_o), 32'd0);
        check("t3_new_addr_ready", 32'(slv_rsp.q_ready), 32'd1);
        tick();
        drive_req(1'b0, 32'h0);
        settle();
        check("t3_new_addr_issued", 32'(outstanding_o), 32'd1);
        drive_req(1'b1, 32'h5);
        settle();
        check("t3_old_addr_blocked", 32'(slv_rsp.q_ready), 32'd0);
        drive_req(1'b1, 32'h9);
        settle();
        check("t3_cur_addr_9", 32'(slv_rsp.q_ready), 32'd1);
        drive_req(1'b0, 32'h0);
        respond(1);
        settle();
        check("t3_drained", 32'(outstanding_o), 32'd0);

        // issue and return in the same cycle
        tick();
        drive_req(1'b1, 32'h5);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h5);
        tick();
        tick();
        check("t4_cnt2", 32'(outstanding_o), 32'd2);
        mst_rsp.p_valid = 1'b1;
        tick();
        mst_rsp.p_valid = 1'b0;
        drive_req(1'b0, 32'h0);
        settle();
        check("t4_same_cycle", 32'(outstanding_o), 32'd2);
        respond(2);
        settle();
        check("t4_drained", 32'(outstanding_o), 32'd0);

        // flush with three in flight
        tick();
        drive_req(1'b1, 32'h5);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h5);
        repeat (3) tick();
        drive_req(1'b0, 32'h0);
        settle();
        check("t5_cnt3", 32'(outstanding_o), 32'd3);
        flush_i = 1'b1;
        tick();
        drive_req(1'b1, 32'h5);
        exp_q.push_back(32'h5);
        settle();
        check("t5_drain_q_ready", 32'(slv_rsp.q_ready), 32'd0);
        check("t5_drain_mst_valid", 32'(mst_req.q_valid), 32'd0);
        check("t5_ack_low", 32'(flush_ack_o), 32'd0);
        mst_rsp.p_valid = 1'b1;
        tick();
        tick();
        settle();
        check("t5_ack_early", 32'(flush_ack_o), 32'd0);
        tick();
        mst_rsp.p_valid = 1'b0;
        settle();
        check("t5_flush_ack", 32'(flush_ack_o), 32'd1);
        check("t5_busy", 32'(busy_o), 32'd0);
        check("t5_flushed_q_ready", 32'(slv_rsp.q_ready), 32'd0);
        flush_i = 1'b0;
        tick();
        settle();
        check("t5_ack_clear", 32'(flush_ack_o), 32'd0);
        check("t5_resume_q_ready", 32'(slv_rsp.q_ready), 32'd1);
        tick();
        drive_req(1'b0, 32'h0);
        settle();
        check("t5_resumed", 32'(outstanding_o), 32'd1);
        respond(1);

        // flush while a valid is stalled downstream
        tick();
        mst_rsp.q_ready = 1'b0;
        drive_req(1'b1, 32'h5);
        exp_q.push_back(32'h5);
        flush_i = 1'b1;
        settle();
        check("t6_stall_valid", 32'(mst_req.q_valid), 32'd1);
        tick();
        settle();
        check("t6_held1", 32'(mst_req.q_valid), 32'd1);
        check("t6_ack_low", 32'(flush_ack_o), 32'd0);
        tick();
        mst_rsp.q_ready = 1'b1;
        settle();
        check("t6_held2", 32'(mst_req.q_valid), 32'd1);
        tick();
        settle();
        check("t6_drain_gates", 32'(mst_req.q_valid), 32'd0);
        check("t6_cnt1", 32'(outstanding_o), 32'd1);
        drive_req(1'b0, 32'h0);
        respond(1);
        settle();
        check("t6_flush_ack", 32'(flush_ack_o), 32'd1);
        check("t6_cnt0", 32'(outstanding_o), 32'd0);
        flush_i = 1'b0;
        tick();
        settle();
        check("t6_ack_clear", 32'(flush_ack_o), 32'd0);

        tick();
        check("sb_all_issued", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/acc_offload_scheduler.md
# acc_offload_scheduler

Per-requester offload scheduler between a requesting core's accelerator C-channel port and its slave port on the accelerator interconnect. It counts in-flight offloads and caps them at `MaxOutstanding`. It holds back any request to a different accelerator address while offloads to the current address are still in flight, so responses from different accelerators cannot return reordered through the interconnect's response arbitration. It also provides a flush handshake that stops new offloads and drains the in-flight ones.

## Interface
- `AddrWidth`, 32: width of `q.addr` (hierarchy plus accelerator portion).
- `MaxOutstanding`, 4: maximum in-flight offloads; ≥1.
- `acc_c_req_t`, logic: C request struct with `q`, `q_valid`, `p_ready`.
- `acc_c_rsp_t`, logic: C response struct with `p`, `p_valid`, `q_ready`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `flush_i`  in  1  level request: stop issuing and drain.
- `flush_ack_o`  out  1  high while drained and flush still requested.
- `busy_o`  out  1  outstanding count ≠ 0.
- `outstanding_o`  out  CntWidth  current in-flight count; CntWidth = `cf_math_pkg::idx_width(MaxOutstanding+1)`.
- `acc_c_slv_req_i`  in  acc_c_req_t  from the core.
- `acc_c_slv_rsp_o`  out  acc_c_rsp_t  to the core.
- `acc_c_mst_req_o`  out  acc_c_req_t  to the interconnect.
- `acc_c_mst_rsp_i`  in  acc_c_rsp_t  from the interconnect.

## Operation
- Payload pass-through:
  - `mst.q = slv.q`.
  - `slv.p = mst.p`; `slv.p_valid = mst.p_valid`; `mst.p_ready = slv.p_ready`.
- Request gating:
  - `mst.q_valid = slv.q_valid & allow`.
  - `slv.q_ready = mst.q_ready & allow`.
- `allow = (state==ACTIVE) & ((cnt==0) | ((slv.q.addr==cur_addr_q) & (cnt<MaxOutstanding)))`.
  - `allow` must not depend on `mst.q_ready`.
- Issue event `iss = mst.q_valid & mst.q_ready`. Return event `ret = mst.p_valid & slv.p_ready`.
- Counter:
  - `iss` only: +1. `ret` only: −1. Both in the same cycle: unchanged.
  - Saturates at 0. A `ret` with cnt==0 is a protocol error, flagged by an assertion.
- `cur_addr_q` loads `slv.q.addr` on every `iss`.
- State machine (ACTIVE, DRAIN, FLUSHED):
  - ACTIVE→DRAIN: `flush_i` high and no stalled issue pending (`!(mst.q_valid & !mst.q_ready)`). A valid already presented downstream is never withdrawn.
  - DRAIN→FLUSHED: next-cycle count is 0.
  - FLUSHED→ACTIVE: `flush_i` low.
  - `flush_ack_o = (state==FLUSHED)`.
  - `flush_i` dropping in DRAIN returns the FSM to ACTIVE.
- Valid stability: while in ACTIVE, an allowed pending request stays allowed. cnt only grows through that request's own handshake, and cur_addr only changes on a handshake.

## Timing
- Request and response paths are combinational, zero latency. Counter, `cur_addr_q` and state update on the rising edge.
- Reset values:
  - cnt=0, `cur_addr_q`=0, state=ACTIVE.
  - `flush_ack_o`=0, `busy_o`=0, `outstanding_o`=0.
  - `mst.q_valid` follows `slv.q_valid`, because allow=1 at cnt 0.
- Full (cnt==MaxOutstanding): `slv.q_ready`=0 until a `ret`. Issue resumes the cycle after the `ret` edge.
- Address switch: the first request to a new address issues in the cycle after cnt reaches 0.
- Simultaneous `ret` and `iss` to the same address while full is impossible, because allow is 0. Issue follows one cycle later.
- Asynchronous reset mid-operation: all state clears immediately. In-flight responses arriving afterwards are the system's responsibility; the counter stays at 0.

## Structure
- State enum `acc_sched_state_e` goes in the shared `acc_pkg`.
- CntWidth is a local parameter.
- Counter is implemented with the common_cells `delta_counter` sub-module (width CntWidth, delta 1).
- Assertions:
  - no underflow;
  - cnt ≤ MaxOutstanding;
  - `mst.q_valid` is stable until `mst.q_ready`.
  - All guarded by `pragma translate_off`.

## Test plan
- Reset → `outstanding_o`=0, `flush_ack_o`=0, `busy_o`=0. One request to addr 0x5 with `mst.q_ready`=1 → `outstanding_o`=1 next cycle.
- MaxOutstanding=4: five back-to-back requests to addr 0x5 with no responses → four issue; the fifth sees `slv.q_ready`=0. One response → the fifth issues the following cycle; count stays 4.
- Two outstanding to 0x5, new request to 0x9 → blocked. Two responses → 0x9 issues the cycle after cnt=0; `cur_addr_q`=0x9.
- Same-cycle issue and response at cnt=2 (addr 0x5) → cnt remains 2.
- Three outstanding, assert `flush_i` → `slv.q_ready`=0 from the next cycle. `flush_ack_o`=1 one cycle after the third response. Deassert `flush_i` → ACTIVE and issuing resumes.
- `flush_i` raised while `mst.q_valid`=1 and `mst.q_ready`=0 → valid is held and the FSM stays ACTIVE until the handshake, then enters DRAIN.
